// File: rtl/mc_control.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback and counts retirements.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap instead of retiring as NOPs.
module mc_control #(
   parameter int unsigned RET_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             iord,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [1:0]       pc_src,
   output logic             pc_write,
   output logic             branch,
   output logic [3:0]       state,
   output logic [RET_W-1:0] retired,
   output logic             illegal_op
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecute  = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiEx   = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11,
      StTrap     = 4'd12
   } state_e;

   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpRtyp = 6'b000000;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpJ    = 6'b000010;

   state_e           state_q, state_d;
   logic             retire;
   logic [RET_W-1:0] retired_q;

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         StFetch:    if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtyp:     state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiEx;
               OpJ:        state_d = StJump;
               default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_d = StTrap;
`else
                  // Unknown opcode retires as a NOP.
                  state_d = StFetch;
                  retire  = 1'b1;
`endif
               end
            endcase
         end
         // opcode[3] separates sw from lw.
         StMemAdr:   state_d = opcode[3] ? StMemWrite : StMemRead;
         StMemRead:  if (mem_ready) state_d = StMemWb;
         StMemWrite: begin
            if (mem_ready) begin
               state_d = StFetch;
               retire  = 1'b1;
            end
         end
         StExecute:  state_d = StAluWb;
         StAddiEx:   state_d = StAddiWb;
         StMemWb, StAluWb, StBranch, StAddiWb, StJump: begin
            state_d = StFetch;
            retire  = 1'b1;
         end
         StTrap:     state_d = StTrap;
         default:    state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire) retired_q <= retired_q + RET_W'(1);
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else if (state_q == StDecode && state_d == StTrap) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   always_comb begin
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      case (state_q)
         StFetch: begin
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         StDecode:   alu_src_b = 2'b11;
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StMemRead:  iord = 1'b1;
         StMemWb: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
         end
         StMemWrite: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         StExecute: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         StAluWb: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         StAddiWb:   reg_write = 1'b1;
         StJump: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: instruction-route reference model checked every cycle, plus directed
// literal checks; a second instance with RET_W=4 exercises counter wrap.
module tb_mc_control;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;

   logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_src;
   logic        pc_write, branch, illegal_op;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        iord4, mem_write4, ir_write4, reg_dst4, mem_to_reg4, reg_write4, alu_src_a4;
   logic [1:0]  alu_src_b4, alu_op4, pc_src4;
   logic        pc_write4, branch4, illegal_op4;
   logic [3:0]  state4;
   logic [3:0]  retired4;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   always #5 clk = ~clk;

   mc_control #(.RET_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_write(pc_write),
      .branch(branch), .state(state), .retired(retired), .illegal_op(illegal_op)
   );

   mc_control #(.RET_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .iord(iord4), .mem_write(mem_write4), .ir_write(ir_write4), .reg_dst(reg_dst4),
      .mem_to_reg(mem_to_reg4), .reg_write(reg_write4), .alu_src_a(alu_src_a4),
      .alu_src_b(alu_src_b4), .alu_op(alu_op4), .pc_src(pc_src4), .pc_write(pc_write4),
      .branch(branch4), .state(state4), .retired(retired4), .illegal_op(illegal_op4)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: each instruction is a queue of steps after DECODE; memory steps wait.
   int          m_state = 0;
   int          m_q[$];
   logic [31:0] m_ret = '0;
   logic        m_ill = 1'b0;
   bit          m_valid = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_state = 0;
         m_q.delete();
         m_ret   = '0;
         m_ill   = 1'b0;
         m_valid = 1'b1;
      end else if (m_state == 0) begin
         if (mem_ready) m_state = 1;
      end else if (m_state == 1) begin
         case (opcode)
            LW:      m_q = {2, 3, 4};
            SW:      m_q = {2, 5};
            RT:      m_q = {6, 7};
            BEQ:     m_q = {8};
            ADDI:    m_q = {9, 10};
            JMP:     m_q = {11};
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
               m_q   = {12};
               m_ill = 1'b1;
`else
               m_q.delete();
`endif
            end
         endcase
         if (m_q.size() == 0) begin
            m_state = 0;
            m_ret++;
         end else m_state = m_q.pop_front();
      end else if (m_state != 12) begin
         if ((m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
         end else if (m_q.size() == 0) begin
            m_state = 0;
            m_ret++;
         end else m_state = m_q.pop_front();
      end
   end

   // Per-state control word straight from the state action table.
   function automatic logic [14:0] exp_ctrl(input int s, input logic mr);
      logic io, mw, irw, rd, m2r, rw, sa, pw, br;
      logic [1:0] sb, op, ps;
      {io, mw, irw, rd, m2r, rw, sa, pw, br} = '0;
      sb = 2'b00; op = 2'b00; ps = 2'b00;
      case (s)
         0:  begin sb = 2'b01; irw = mr; pw = mr; end
         1:  sb = 2'b11;
         2:  begin sa = 1'b1; sb = 2'b10; end
         3:  io = 1'b1;
         4:  begin m2r = 1'b1; rw = 1'b1; end
         5:  begin io = 1'b1; mw = 1'b1; end
         6:  begin sa = 1'b1; op = 2'b10; end
         7:  begin rd = 1'b1; rw = 1'b1; end
         8:  begin sa = 1'b1; op = 2'b01; ps = 2'b01; br = 1'b1; end
         9:  begin sa = 1'b1; sb = 2'b10; end
         10: rw = 1'b1;
         11: begin ps = 2'b10; pw = 1'b1; end
         default: ;
      endcase
      return {io, mw, irw, rd, m2r, rw, sa, sb, op, ps, pw, br};
   endfunction

   always @(negedge clk) begin
      if (m_valid) begin
         chk("state", state, m_state);
         chk("ctrl", {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_src, pc_write, branch}, exp_ctrl(m_state, mem_ready));
         chk("retired", retired, m_ret);
         chk("illegal_op", illegal_op, m_ill);
         chk("state4", state4, m_state);
         chk("retired4", retired4, m_ret[3:0]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int seq_lw[5]   = '{1, 2, 3, 4, 0};
   int seq_mix[10] = '{1, 6, 7, 0, 1, 8, 0, 1, 11, 0};
   logic [5:0] ops[8] = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111, 6'b001111};

   initial begin
      int ninst;
      rst_n = 1'b0; mem_ready = 1'b1; opcode = LW;
      tick(2);
      chk("rst_state", state, 0);
      chk("rst_retired", retired, 0);
      chk("rst_ir_write", ir_write, 1);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_alu_src_b", alu_src_b, 2'b01);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("lw_state", state, seq_lw[i]);
         chk("lw_reg_write", reg_write, seq_lw[i] == 4);
         chk("lw_mem_to_reg", mem_to_reg, seq_lw[i] == 4);
      end
      chk("lw_retired", retired, 1);

      tick(3);
      chk("abort_in_memread", state, 3);
      rst_n = 1'b0;
      tick(1);
      chk("abort_state", state, 0);
      chk("abort_retired", retired, 0);
      rst_n = 1'b1;

      opcode = SW;
      tick(3);
      chk("sw_state", state, 5);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("sw_stall_mem_write", mem_write, 1);
         chk("sw_stall_state", state, 5);
         tick(1);
      end
      mem_ready = 1'b1;
      chk("sw_last_mem_write", mem_write, 1);
      tick(1);
      chk("sw_done_state", state, 0);
      chk("sw_retired", retired, 1);

      opcode = RT;
      ninst = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("mix_state", state, seq_mix[i]);
         if (seq_mix[i] == 6) chk("rtype_alu_op", alu_op, 2'b10);
         if (seq_mix[i] == 8) chk("beq_alu_op_branch", {alu_op, branch}, 3'b011);
         if (seq_mix[i] == 11) chk("j_pc_src_pc_write", {pc_src, pc_write}, 3'b101);
         if (seq_mix[i] == 0) begin
            ninst++;
            opcode = (ninst == 1) ? BEQ : JMP;
         end
      end
      chk("mix_retired", retired, 4);

      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      opcode = ADDI;
      tick(60);
      chk("addi15_retired4", retired4, 15);
      tick(4);
      chk("addi16_retired4_wrap", retired4, 0);
      chk("addi16_retired", retired, 16);
      chk("addi16_state", state, 0);

      opcode = 6'b111111;
      tick(2);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      chk("trap_state", state, 12);
      chk("trap_flag", illegal_op, 1);
      tick(20);
      chk("trap_hold_state", state, 12);
      chk("trap_hold_flag", illegal_op, 1);
      chk("trap_retired", retired, 16);
      rst_n = 1'b0;
      tick(1);
      chk("trap_reset_state", state, 0);
      chk("trap_reset_flag", illegal_op, 0);
      rst_n = 1'b1;
`else
      chk("nop_state", state, 0);
      chk("nop_retired", retired, 17);
      chk("nop_flag", illegal_op, 0);
`endif

      for (int i = 0; i < 4000; i++) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         if (m_state == 0) opcode = ops[$urandom_range(0, 7)];
         if (m_state == 12) rst_n = ($urandom_range(0, 7) != 0);
         else rst_n = ($urandom_range(0, 299) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      tick(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
